xdatabus_arb: RTL and testbench
===============================

Name: xdatabus_arb

Overview:
- Round-robin arbiter that shares one external databus slave port among the data engine's vread/vwrite databus masters (nIO masters).
- Sits between the engine's packed m_databus_* bundle and the single system memory/cache port.
- Grants one master at a time and holds the grant until that transaction completes.
- Forwards addr/wdata/wstrb downstream and returns ready/rdata only to the granted master.

Parameters:
N_MASTERS, 4, number of requesting masters (engine nIO)
ADDR_W, 32, databus address width (engine IO_ADDR_W)
DATA_W, 32, databus data width (engine DATAPATH_W)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m_valid  in  N_MASTERS  per-master request; master 0 in bit N_MASTERS-1
m_ready  out  N_MASTERS  per-master completion pulse, same packing
m_addr  in  N_MASTERS*ADDR_W  packed addresses; master 0 in the top slice
m_wdata  in  N_MASTERS*DATA_W  packed write data; master 0 in the top slice
m_wstrb  in  N_MASTERS*DATA_W/8  packed byte strobes; all-zero means read
m_rdata  out  N_MASTERS*DATA_W  packed read data; master 0 in the top slice
s_valid  out  1  downstream request
s_ready  in  1  downstream completion (one-cycle pulse)
s_addr  out  ADDR_W  forwarded address
s_wdata  out  DATA_W  forwarded write data
s_wstrb  out  DATA_W/8  forwarded strobes
s_rdata  in  DATA_W  downstream read data, valid with s_ready
busy  out  1  a grant is held

Behaviour:
- Clock and reset: single clock clk; synchronous active-high reset rst.
- Reset values:
  - state IDLE, grant index 0, round-robin pointer 0.
  - s_valid=0, busy=0, m_ready=0.
  - s_addr/s_wdata/s_wstrb=0.
- States: IDLE, BUSY.
- IDLE:
  - If any m_valid bit is set, pick the first requester at or after the pointer, in index order with wrap-around.
  - Latch its index as the grant; go to BUSY next cycle.
  - No requests: stay in IDLE.
- BUSY:
  - s_valid = m_valid[grant].
  - s_addr/s_wdata/s_wstrb = granted master's slices.
  - All of these are driven combinationally from the latched grant, so a master may update its fields only after its ready pulse.
- Completion:
  - In BUSY with s_ready=1: m_ready[grant]=1 for that cycle only.
  - m_rdata slice[grant]=s_rdata in the same cycle (combinational pass-through).
  - Pointer becomes (grant+1) mod N_MASTERS; state returns to IDLE.
- Latency: request to s_valid is 1 cycle (the arbitration cycle). Back-to-back grants need at least 2 cycles per transaction.
- Non-granted masters:
  - m_ready bits stay 0.
  - m_rdata slices are 0 (all slices zero except the granted one on its ready cycle).
- Protocol violation (granted m_valid drops in BUSY before s_ready):
  - s_valid follows the drop.
  - Arbiter returns to IDLE next cycle; the pointer still advances past the grant.
- s_ready in IDLE is ignored.
- A new request arriving during BUSY waits; it is never preempted.
- Starvation bound: every requester is granted within N_MASTERS transactions.
- rst during BUSY: the in-flight transaction is abandoned and s_valid drops next cycle. Downstream is required to tolerate this; the engine is reset together with the arbiter.

Optional Feature:
- Macro: XDATABUS_ARB_FIXED_PRIO_EN.
- Defined: the round-robin pointer is removed; IDLE always grants the lowest-index (highest packed) requesting master. Starvation is allowed by design and used for latency-critical vread 0.
- Undefined: round-robin as above.

Decomposition:
- xversat.vh: packing helpers, shared with the engine:
  - slice macros for master i (top index N*W-1-i*W).
  - IDLE/BUSY state encodings.
- One sub-module xrr_pick: combinational priority picker taking request vector and pointer, returning index and found flag.
  - The fixed-priority build ties the pointer to 0.
- Everything else (FSM, muxes, demux) in xdatabus_arb.

Test Plan:
- Single read, N=4: master 2 requests addr 0x100, strb 0.
  - s_valid rises 1 cycle later with s_addr=0x100.
  - Slave returns 0xDEADBEEF with s_ready: m_ready=0b0010 for one cycle, m_rdata slice 2=0xDEADBEEF.
- Round-robin fairness: all four masters hold valid continuously, slave always ready next cycle.
  - Grant order 0,1,2,3,0 repeating.
  - No master receives two grants before each other master receives one.
- Write forwarding: master 3 writes addr 0x40, wdata 0x12345678, strb 0xF.
  - s_* match exactly.
  - m_ready bit 0 (master 3) pulses once; other bits stay 0.
- Reset mid-transaction: rst asserted in BUSY for master 1.
  - Next cycle: s_valid=0, busy=0, pointer 0.
  - With masters 1 and 3 then requesting, master 1 is granted first.
- Valid drop: granted master 0 deasserts valid before s_ready.
  - s_valid falls the same cycle.
  - Arbiter returns to IDLE; next grant goes to master 1 if requesting.
- Fixed priority (macro defined): masters 0 and 2 request continuously; master 2 is never granted while master 0 requests.

Source files
------------

// File: rtl/xdatabus_arb_pkg.sv
// Shared types and packing helpers for the databus arbiter.
// Master i occupies the slice whose top bit is N*W-1-i*W (master 0 in the top slice).
package xdatabus_arb_pkg;

    localparam int N_MASTERS_DEF = 4;
    localparam int ADDR_W_DEF    = 32;
    localparam int DATA_W_DEF    = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int slice_lo(input int idx, input int n, input int w);
        return (n - 1 - idx) * w;
    endfunction

endpackage

// File: rtl/xdatabus_arb_if.sv
// Packed engine-side and memory-side databus signals.
// The master modport is the environment (engine + memory); the slave modport is the arbiter.
interface xdatabus_arb_if
    import xdatabus_arb_pkg::*;
#(
    parameter int N_MASTERS = N_MASTERS_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
);
    localparam int STRB_W = DATA_W / 8;

    logic [N_MASTERS-1:0]        m_valid;
    logic [N_MASTERS-1:0]        m_ready;
    logic [N_MASTERS*ADDR_W-1:0] m_addr;
    logic [N_MASTERS*DATA_W-1:0] m_wdata;
    logic [N_MASTERS*STRB_W-1:0] m_wstrb;
    logic [N_MASTERS*DATA_W-1:0] m_rdata;
    logic                        s_valid;
    logic                        s_ready;
    logic [ADDR_W-1:0]           s_addr;
    logic [DATA_W-1:0]           s_wdata;
    logic [STRB_W-1:0]           s_wstrb;
    logic [DATA_W-1:0]           s_rdata;

    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        input  m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb
    );

    modport slave (
        input  m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        output m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb
    );

endinterface

// File: rtl/xdatabus_arb_xrr_pick.sv
// Combinational rotating priority picker: first set request at or after ptr, with wrap.
// req bit i belongs to master i (already unpacked from the engine's reversed order).
module xrr_pick
    import xdatabus_arb_pkg::*;
#(
    parameter int N     = N_MASTERS_DEF,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/xdatabus_arb.sv
// Round-robin arbiter sharing one databus slave port among N_MASTERS engine masters.
// Define XDATABUS_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer).
//
// state | meaning
// IDLE  | no grant held; arbitrate among m_valid this cycle
// BUSY  | grant held; forward granted master until s_ready or its valid drops
module xdatabus_arb
    import xdatabus_arb_pkg::*;
#(
    parameter int N_MASTERS = N_MASTERS_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    xdatabus_arb_if.slave bus,
    output logic          busy
);

    localparam int IDX_W  = idx_w(N_MASTERS);
    localparam int STRB_W = DATA_W / 8;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            grant_q, grant_d;
    logic [IDX_W-1:0]            pick_idx, pick_ptr, next_ptr;
    logic                        pick_found;
    logic [N_MASTERS-1:0]        req;
    logic                        gnt_valid, done, release_gnt;
    logic [ADDR_W-1:0]           s_addr_v;
    logic [DATA_W-1:0]           s_wdata_v;
    logic [STRB_W-1:0]           s_wstrb_v;
    logic [N_MASTERS-1:0]        ready_v;
    logic [N_MASTERS*DATA_W-1:0] rdata_v;

    assign busy        = (state_q == BUSY);
    assign done        = busy && bus.s_ready;
    assign release_gnt = busy && (done || !gnt_valid);
    assign next_ptr    = (grant_q == IDX_W'(N_MASTERS - 1)) ? '0 : grant_q + 1'b1;

    // Everything downstream follows the latched grant combinationally; zero when idle.
    always_comb begin
        req       = '0;
        gnt_valid = 1'b0;
        s_addr_v  = '0;
        s_wdata_v = '0;
        s_wstrb_v = '0;
        ready_v   = '0;
        rdata_v   = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            req[i] = bus.m_valid[N_MASTERS-1-i];
            if (busy && grant_q == IDX_W'(i)) begin
                gnt_valid = bus.m_valid[N_MASTERS-1-i];
                s_addr_v  = bus.m_addr[slice_lo(i, N_MASTERS, ADDR_W) +: ADDR_W];
                s_wdata_v = bus.m_wdata[slice_lo(i, N_MASTERS, DATA_W) +: DATA_W];
                s_wstrb_v = bus.m_wstrb[slice_lo(i, N_MASTERS, STRB_W) +: STRB_W];
                if (bus.s_ready) begin
                    ready_v[N_MASTERS-1-i] = 1'b1;
                    rdata_v[slice_lo(i, N_MASTERS, DATA_W) +: DATA_W] = bus.s_rdata;
                end
            end
        end
    end

    assign bus.s_valid = gnt_valid;
    assign bus.s_addr  = s_addr_v;
    assign bus.s_wdata = s_wdata_v;
    assign bus.s_wstrb = s_wstrb_v;
    assign bus.m_ready = ready_v;
    assign bus.m_rdata = rdata_v;

`ifdef XDATABUS_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [IDX_W-1:0] ptr_q;

    // Pointer advances past the grant on completion and on a dropped request alike.
    always_ff @(posedge clk) begin
        if (rst)
            ptr_q <= '0;
        else if (release_gnt)
            ptr_q <= next_ptr;
    end

    assign pick_ptr = ptr_q;
`endif

    xrr_pick #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    grant_d = pick_idx;
                end
            end
            BUSY: begin
                if (release_gnt)
                    state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_xdatabus_arb.sv
// Self-checking bench for xdatabus_arb: vector table, corner sequences and a random run
// against a transaction-level model. Honours XDATABUS_ARB_FIXED_PRIO_EN like the design.
module tb_xdatabus_arb;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    xdatabus_arb_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    xdatabus_arb #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  valid;
        int          who;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        s_ready;
        logic [31:0] s_rdata;
        logic        e_sv;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
        logic [3:0]  e_mready;
        logic        e_busy;
        logic [31:0] e_rslice;
    } vec_t;

    vec_t vt [16];

    // random-phase per-master request state
    logic        pv [N];
    logic [31:0] pa [N];
    logic [31:0] pd [N];
    logic [3:0]  ps [N];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.m_valid = '0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.m_wstrb = '0;
        bus.s_ready = 1'b0;
        bus.s_rdata = '0;
    endtask

    task automatic set_fields(input int i, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s);
        bus.m_addr[(N-1-i)*AW +: AW]  = a;
        bus.m_wdata[(N-1-i)*DW +: DW] = d;
        bus.m_wstrb[(N-1-i)*SW +: SW] = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic int ready_idx(input logic [3:0] r);
        int idx = -1;
        for (int i = 0; i < N; i++)
            if (r[N-1-i]) idx = i;
        return idx;
    endfunction

    // Grants observed while every master listed in `who` holds a request continuously.
    task automatic run_grants(input logic [3:0] vmask, input int n_grants, input int stride,
                              input string name);
        int got = 0;
        do_reset();
        bus.m_valid = vmask;
        for (int i = 0; i < N; i++) set_fields(i, 32'h1000 * (i + 1), 32'h0, 4'h0);
        for (int c = 0; c < 200 && got < n_grants; c++) begin
            tick();
            bus.s_ready = 1'b0;
            #1;
            if (bus.s_valid) begin
                bus.s_ready = 1'b1;
                bus.s_rdata = 32'(c);
                #1;
                chk(name, 128'(ready_idx(bus.m_ready)), 128'((got * stride) % N));
                chk({name, "_addr"}, bus.s_addr, 128'(32'h1000 * ((got * stride) % N + 1)));
                got++;
            end
        end
        chk({name, "_count"}, 128'(got), 128'(n_grants));
        clear_inputs();
    endtask

    logic        mbusy;
    int          mg, mptr;
    logic [127:0] er;
    logic [3:0]  emr;
    logic        rnd_rst;

    initial begin
        vt[0]  = '{4'b0010, 2, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0,        4'h0, 4'b0000, 1'b0, 32'h0};
        vt[1]  = '{4'b0010, 2, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0,        1'b1, 32'h100, 32'h0,        4'h0, 4'b0000, 1'b1, 32'h0};
        vt[2]  = '{4'b0010, 2, 32'h100, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b1, 32'h100, 32'h0,        4'h0, 4'b0010, 1'b1, 32'hDEADBEEF};
        vt[3]  = '{4'b0000, 2, 32'h0,   32'h0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0,        4'h0, 4'b0000, 1'b0, 32'h0};
        vt[4]  = '{4'b0001, 3, 32'h40, 32'h12345678, 4'hF, 1'b0, 32'h0,  1'b0, 32'h0,   32'h0,        4'h0, 4'b0000, 1'b0, 32'h0};
        vt[5]  = '{4'b0001, 3, 32'h40, 32'h12345678, 4'hF, 1'b0, 32'h0,  1'b1, 32'h40,  32'h12345678, 4'hF, 4'b0000, 1'b1, 32'h0};
        vt[6]  = '{4'b0001, 3, 32'h40, 32'h12345678, 4'hF, 1'b1, 32'hAAAA5555, 1'b1, 32'h40, 32'h12345678, 4'hF, 4'b0001, 1'b1, 32'hAAAA5555};
        vt[7]  = '{4'b0000, 3, 32'h0,   32'h0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0,        4'h0, 4'b0000, 1'b0, 32'h0};
        vt[8]  = '{4'b0000, 3, 32'h0,   32'h0, 4'h0, 1'b1, 32'h123,      1'b0, 32'h0,   32'h0,        4'h0, 4'b0000, 1'b0, 32'h0};
        vt[9]  = '{4'b1010, 0, 32'h200, 32'h0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0,        4'h0, 4'b0000, 1'b0, 32'h0};
        vt[10] = '{4'b1010, 0, 32'h200, 32'h0, 4'h0, 1'b0, 32'h0,        1'b1, 32'h200, 32'h0,        4'h0, 4'b0000, 1'b1, 32'h0};
        vt[11] = '{4'b1010, 0, 32'h200, 32'h0, 4'h0, 1'b1, 32'h55,       1'b1, 32'h200, 32'h0,        4'h0, 4'b1000, 1'b1, 32'h55};
        vt[12] = '{4'b0010, 2, 32'h300, 32'h0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0,        4'h0, 4'b0000, 1'b0, 32'h0};
        vt[13] = '{4'b0010, 2, 32'h300, 32'h0, 4'h0, 1'b0, 32'h0,        1'b1, 32'h300, 32'h0,        4'h0, 4'b0000, 1'b1, 32'h0};
        vt[14] = '{4'b0000, 2, 32'h0,   32'h0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0,        4'h0, 4'b0000, 1'b1, 32'h0};
        vt[15] = '{4'b0000, 2, 32'h0,   32'h0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0,        4'h0, 4'b0000, 1'b0, 32'h0};

        do_reset();
        #1;
        chk("rst_s_valid", bus.s_valid, 1'b0);
        chk("rst_busy",    busy,        1'b0);
        chk("rst_m_ready", bus.m_ready, 4'b0);
        chk("rst_s_addr",  bus.s_addr,  32'h0);
        chk("rst_s_wdata", bus.s_wdata, 32'h0);
        chk("rst_s_wstrb", bus.s_wstrb, 4'h0);
        chk("rst_m_rdata", bus.m_rdata, 128'h0);

        for (int r = 0; r < 16; r++) begin
            tick();
            clear_inputs();
            bus.m_valid = vt[r].valid;
            set_fields(vt[r].who, vt[r].addr, vt[r].wdata, vt[r].strb);
            bus.s_ready = vt[r].s_ready;
            bus.s_rdata = vt[r].s_rdata;
            #1;
            er = '0;
            if (vt[r].e_mready != 4'b0) er[(N-1-vt[r].who)*DW +: DW] = vt[r].e_rslice;
            chk($sformatf("vec%0d_s_valid", r), bus.s_valid, vt[r].e_sv);
            chk($sformatf("vec%0d_s_addr", r),  bus.s_addr,  vt[r].e_addr);
            chk($sformatf("vec%0d_s_wdata", r), bus.s_wdata, vt[r].e_wdata);
            chk($sformatf("vec%0d_s_wstrb", r), bus.s_wstrb, vt[r].e_strb);
            chk($sformatf("vec%0d_m_ready", r), bus.m_ready, vt[r].e_mready);
            chk($sformatf("vec%0d_busy", r),    busy,        vt[r].e_busy);
            chk($sformatf("vec%0d_m_rdata", r), bus.m_rdata, er);
        end

`ifdef XDATABUS_ARB_FIXED_PRIO_EN
        run_grants(4'b1010, 8, 0, "fixed_prio");
`else
        run_grants(4'b1111, 12, 1, "rr_order");
`endif

        // reset while master 1 holds the grant
        do_reset();
        bus.m_valid = 4'b0100;
        set_fields(1, 32'h1100, 32'h0, 4'h0);
        set_fields(3, 32'h3300, 32'h0, 4'h0);
        tick();
        tick();
        #1;
        chk("rstmid_busy_before", busy, 1'b1);
        chk("rstmid_addr_before", bus.s_addr, 32'h1100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.m_valid = 4'b0101;
        #1;
        chk("rstmid_s_valid", bus.s_valid, 1'b0);
        chk("rstmid_busy",    busy,        1'b0);
        tick();
        #1;
        chk("rstmid_regrant_valid", bus.s_valid, 1'b1);
        chk("rstmid_regrant_addr",  bus.s_addr,  32'h1100);

        // granted master 0 drops valid before s_ready
        do_reset();
        bus.m_valid = 4'b1100;
        set_fields(0, 32'h0A0, 32'h0, 4'h0);
        set_fields(1, 32'h1A0, 32'h0, 4'h0);
        tick();
        tick();
        #1;
        chk("drop_granted_valid", bus.s_valid, 1'b1);
        chk("drop_granted_addr",  bus.s_addr,  32'h0A0);
        bus.m_valid = 4'b0100;
        #1;
        chk("drop_s_valid_same_cycle", bus.s_valid, 1'b0);
        tick();
        #1;
        chk("drop_back_idle", busy, 1'b0);
        tick();
        #1;
        chk("drop_next_valid", bus.s_valid, 1'b1);
        chk("drop_next_addr",  bus.s_addr,  32'h1A0);

        // random traffic against a transaction-level model
        do_reset();
        mbusy = 1'b0;
        mg    = 0;
        mptr  = 0;
        for (int i = 0; i < N; i++) begin
            pv[i] = 1'b0; pa[i] = '0; pd[i] = '0; ps[i] = '0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            rnd_rst = ($urandom_range(0, 149) == 0);
            rst = rnd_rst;
            for (int i = 0; i < N; i++) begin
                if (pv[i]) begin
                    if ($urandom_range(0, 31) == 0) pv[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    pv[i] = 1'b1;
                    pa[i] = $urandom;
                    pd[i] = $urandom;
                    ps[i] = 4'($urandom_range(0, 15));
                end
                bus.m_valid[N-1-i] = pv[i];
                set_fields(i, pa[i], pd[i], ps[i]);
            end
            bus.s_ready = 1'($urandom_range(0, 1));
            bus.s_rdata = $urandom;
            #1;
            er  = '0;
            emr = '0;
            if (mbusy && bus.s_ready) begin
                emr[N-1-mg] = 1'b1;
                er[(N-1-mg)*DW +: DW] = bus.s_rdata;
            end
            chk("rnd_s_valid", bus.s_valid, mbusy && pv[mg]);
            chk("rnd_s_addr",  bus.s_addr,  mbusy ? pa[mg] : 32'h0);
            chk("rnd_s_wdata", bus.s_wdata, mbusy ? pd[mg] : 32'h0);
            chk("rnd_s_wstrb", bus.s_wstrb, mbusy ? ps[mg] : 4'h0);
            chk("rnd_m_ready", bus.m_ready, emr);
            chk("rnd_m_rdata", bus.m_rdata, er);
            chk("rnd_busy",    busy,        mbusy);
            // advance the model across the coming edge
            if (rnd_rst) begin
                mbusy = 1'b0; mg = 0; mptr = 0;
                for (int i = 0; i < N; i++) pv[i] = 1'b0;
            end else if (!mbusy) begin
`ifdef XDATABUS_ARB_FIXED_PRIO_EN
                mptr = 0;
`endif
                for (int k = N - 1; k >= 0; k--)
                    if (pv[(mptr + k) % N]) begin
                        mbusy = 1'b1;
                        mg    = (mptr + k) % N;
                    end
            end else if (bus.s_ready || !pv[mg]) begin
                if (bus.s_ready) pv[mg] = 1'b0;
                mbusy = 1'b0;
                mptr  = (mg + 1) % N;
            end
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
